// File: rtl/mpadd_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
// Optional subtract mode is enabled by defining MPADD_SUB_EN.
package mpadd_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS1 = 2'd1,
    S_PASS2 = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Limb counter needs at least one bit even for single-limb operands.
  function automatic int cnt_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/kogge_stone_32.sv
// 32-bit Kogge-Stone parallel-prefix adder without carry-in.
module kogge_stone_32
  import mpadd_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  always_comb begin
    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] p;
    logic [WORD_W-1:0] gn;
    logic [WORD_W-1:0] pn;
    g  = a & b;
    p  = a ^ b;
    gn = g;
    pn = p;
    // Five prefix levels with span 1, 2, 4, 8, 16.
    for (int l = 0; l < 5; l++) begin
      gn = g;
      pn = p;
      for (int i = (1 << l); i < WORD_W; i++) begin
        gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
        pn[i] = p[i] & p[i - (1 << l)];
      end
      g = gn;
      p = pn;
    end
    sum  = (a ^ b) ^ {g[WORD_W-2:0], 1'b0};
    cout = g[WORD_W-1];
  end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: one limb per handshake, LS limb first,
// carry injected via a second +1 pass. Define MPADD_SUB_EN for A-B mode.
//
// state   | meaning
// S_IDLE  | waiting for an operand limb (in_ready=1)
// S_PASS1 | adder computes ra+rb
// S_PASS2 | adder computes rs+1 to absorb the incoming carry
// S_OUT   | result limb presented until accepted
module mp_add_seq
  import mpadd_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_cout
`ifdef MPADD_SUB_EN
  ,
  input  logic              sub
`endif
);

  localparam int CW = cnt_w(WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     limb_cnt_q;
  logic              carry_q;
  logic              c1_q;
  logic [WORD_W-1:0] ra_q, rb_q, rs_q;
  logic [WORD_W-1:0] add_a, add_b, add_sum;
  logic              add_cout;
  logic              is_last;
  logic              in_fire, out_fire;
  logic              sub_eff;

`ifdef MPADD_SUB_EN
  logic sub_q;

  // Mode is taken live on limb 0 and frozen for the rest of the operand.
  assign sub_eff = (limb_cnt_q == '0) ? sub : sub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (in_fire && limb_cnt_q == '0) begin
      sub_q <= sub;
    end
  end
`else
  assign sub_eff = 1'b0;
`endif

  assign is_last  = (limb_cnt_q == LAST_IDX);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign add_a = (state_q == S_PASS2) ? rs_q : ra_q;
  assign add_b = (state_q == S_PASS2) ? WORD_W'(1) : rb_q;

  kogge_stone_32 u_adder (
    .a    (add_a),
    .b    (add_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_sum   = '0;
    out_last  = 1'b0;
    out_cout  = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_PASS1;
      end
      S_PASS1: state_d = carry_q ? S_PASS2 : S_OUT;
      S_PASS2: state_d = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        out_sum   = rs_q;
        out_last  = is_last;
        out_cout  = is_last & carry_q;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limb_cnt_q <= '0;
      carry_q    <= 1'b0;
      c1_q       <= 1'b0;
      ra_q       <= '0;
      rb_q       <= '0;
      rs_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_fire) begin
            ra_q <= in_a;
            rb_q <= in_b ^ {WORD_W{sub_eff}};
            if (limb_cnt_q == '0) carry_q <= sub_eff;
          end
        end
        S_PASS1: begin
          rs_q <= add_sum;
          if (carry_q) c1_q <= add_cout;
          else         carry_q <= add_cout;
        end
        S_PASS2: begin
          // a+b and +1 cannot both overflow, so OR merges the carries.
          rs_q    <= add_sum;
          carry_q <= c1_q | add_cout;
        end
        S_OUT: begin
          if (out_fire) begin
            if (is_last) begin
              limb_cnt_q <= '0;
              carry_q    <= 1'b0;
            end else begin
              limb_cnt_q <= limb_cnt_q + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq; expected limbs come from a 33-bit model.
module tb_mp_add_seq;

  localparam int WORDS = 4;

  typedef struct {
    logic [31:0] sum;
    logic        last;
    logic        cout;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_last;
  logic        out_cout;
`ifdef MPADD_SUB_EN
  logic        sub;
`endif

  int   cyc;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];

  mp_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout)
`ifdef MPADD_SUB_EN
    ,
    .sub       (sub)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model_limb(input logic [31:0] a, input logic [31:0] b,
                                      input logic cin, input int idx, input logic sub_m,
                                      output logic cnext);
    exp_t        e;
    logic [32:0] t;
    logic [31:0] bb;
    bb     = sub_m ? ~b : b;
    t      = {1'b0, a} + {1'b0, bb} + {32'd0, cin};
    e.sum  = t[31:0];
    e.last = (idx == WORDS - 1);
    e.cout = e.last ? t[32] : 1'b0;
    e.lat  = cin ? 3 : 2;
    cnext  = t[32];
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic drive_limb(input logic [31:0] a, input logic [31:0] b,
                            output int acc_cyc, output bit ok);
    ok       = 1'b0;
    acc_cyc  = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok      = 1'b1;
        acc_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Returns at the negedge where out_valid is first seen (no transfer yet).
  task automatic wait_out(output logic [31:0] s, output logic l, output logic co,
                          output int oc, output bit ok);
    ok = 1'b0;
    s  = '0;
    l  = 1'b0;
    co = 1'b0;
    oc = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        s  = out_sum;
        l  = out_last;
        co = out_cout;
        oc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
`ifdef MPADD_SUB_EN
    sub       = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_sum !== 32'd0) begin n_err++; $display("FAIL reset_out_sum got %h want 0", out_sum); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got %b want 0", out_last); end
    n_cmp++; if (out_cout !== 1'b0) begin n_err++; $display("FAIL reset_out_cout got %b want 0", out_cout); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  // Basic sums, full carry ripple, pass2 carry-out chain, random operands.
  task automatic test_add_table();
    logic [31:0] va [4][WORDS];
    logic [31:0] vb [4][WORDS];
    logic        c;
    logic [31:0] os;
    logic        ol, oc;
    int          acc, ocyc;
    bit          ok;
    exp_t        e;
    for (int i = 0; i < WORDS; i++) begin
      va[0][i] = 32'(i + 1);
      vb[0][i] = 32'((i + 1) * 10);
      va[1][i] = 32'hFFFF_FFFF;
      vb[1][i] = (i == 0) ? 32'd1 : 32'd0;
      va[3][i] = $urandom;
      vb[3][i] = $urandom;
    end
    va[2][0] = 32'hFFFF_FFFF; vb[2][0] = 32'd1;
    va[2][1] = 32'hFFFF_FFFF; vb[2][1] = 32'd0;
    va[2][2] = 32'd5;         vb[2][2] = 32'd6;
    va[2][3] = 32'hFFFF_FFFF; vb[2][3] = 32'hFFFF_FFFF;
    for (int s = 0; s < 4; s++) begin
      c = 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        drive_limb(va[s][i], vb[s][i], acc, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL accept set%0d limb%0d in_ready got 0 want 1", s, i); end
        sb.push_back(model_limb(va[s][i], vb[s][i], c, i, 1'b0, c));
        wait_out(os, ol, oc, ocyc, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok) begin
          n_err++; $display("FAIL timeout set%0d limb%0d out_valid got 0 want 1", s, i);
        end else begin
          if (os !== e.sum) begin n_err++; $display("FAIL sum set%0d limb%0d got %h want %h", s, i, os, e.sum); end
          n_cmp++; if (ol !== e.last) begin n_err++; $display("FAIL last set%0d limb%0d got %b want %b", s, i, ol, e.last); end
          n_cmp++; if (oc !== e.cout) begin n_err++; $display("FAIL cout set%0d limb%0d got %b want %b", s, i, oc, e.cout); end
          n_cmp++; if (ocyc - acc !== e.lat) begin n_err++; $display("FAIL latency set%0d limb%0d got %0d want %0d", s, i, ocyc - acc, e.lat); end
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] os;
    logic        ol, oc, c;
    int          acc, ocyc;
    bit          ok;
    exp_t        e;
    c = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      if (i == 1) out_ready = 1'b0;
      drive_limb(32'hFFFF_FFF0 + 32'(i), 32'h20 + 32'(i), acc, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_accept limb%0d in_ready got 0 want 1", i); end
      sb.push_back(model_limb(32'hFFFF_FFF0 + 32'(i), 32'h20 + 32'(i), c, i, 1'b0, c));
      wait_out(os, ol, oc, ocyc, ok);
      e = sb.pop_front();
      if (i == 1 && ok) begin
        for (int k = 0; k < 5; k++) begin
          in_valid = 1'b1;
          in_a     = 32'hDEAD_0000 + 32'(k);
          in_b     = 32'hBEEF_0000;
          n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid cyc%0d got %b want 1", k, out_valid); end
          n_cmp++; if (out_sum !== e.sum) begin n_err++; $display("FAIL stall_hold cyc%0d got %h want %h", k, out_sum, e.sum); end
          n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready cyc%0d got %b want 0", k, in_ready); end
          @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      n_cmp++;
      if (!ok) begin
        n_err++; $display("FAIL stall_timeout limb%0d out_valid got 0 want 1", i);
      end else begin
        if (os !== e.sum) begin n_err++; $display("FAIL stall_sum limb%0d got %h want %h", i, os, e.sum); end
        n_cmp++; if (ol !== e.last || oc !== e.cout) begin n_err++; $display("FAIL stall_last_cout limb%0d got %b%b want %b%b", i, ol, oc, e.last, e.cout); end
        @(negedge clk);
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] os;
    logic        ol, oc, c;
    int          acc, ocyc;
    bit          ok;
    exp_t        e;
    c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_limb(32'hFFFF_FFFF, (i == 0) ? 32'd1 : 32'd0, acc, ok);
      sb.push_back(model_limb(32'hFFFF_FFFF, (i == 0) ? 32'd1 : 32'd0, c, i, 1'b0, c));
      if (i < 2) begin
        wait_out(os, ol, oc, ocyc, ok);
        e = sb.pop_front();
        n_cmp++; if (!ok || os !== e.sum) begin n_err++; $display("FAIL rstmid_pre limb%0d got %h want %h", i, os, e.sum); end
        if (ok) @(negedge clk);
      end
    end
    // Limb 2 has carry-in 1: one negedge after accept it sits in the +1 pass.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    repeat (4) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_stale out_valid got %b want 0", out_valid); end
    end
    c = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      drive_limb(32'd7 + 32'(i), 32'(i + 1), acc, ok);
      sb.push_back(model_limb(32'd7 + 32'(i), 32'(i + 1), c, i, 1'b0, c));
      wait_out(os, ol, oc, ocyc, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok) begin
        n_err++; $display("FAIL rstmid_timeout limb%0d out_valid got 0 want 1", i);
      end else begin
        if (os !== e.sum) begin n_err++; $display("FAIL rstmid_sum limb%0d got %h want %h", i, os, e.sum); end
        n_cmp++; if (ol !== e.last) begin n_err++; $display("FAIL rstmid_last limb%0d got %b want %b", i, ol, e.last); end
        n_cmp++; if (ocyc - acc !== e.lat) begin n_err++; $display("FAIL rstmid_latency limb%0d got %0d want %0d", i, ocyc - acc, e.lat); end
        @(negedge clk);
      end
    end
  endtask

`ifdef MPADD_SUB_EN
  task automatic test_sub();
    logic [31:0] va [2][WORDS];
    logic [31:0] vb [2][WORDS];
    logic [31:0] os;
    logic        ol, oc, c;
    int          acc, ocyc;
    bit          ok;
    exp_t        e;
    for (int i = 0; i < WORDS; i++) begin
      va[0][i] = 32'd0;
      vb[0][i] = (i == 0) ? 32'd1 : 32'd0;
      va[1][i] = (i == 0) ? 32'd5 : 32'd0;
      vb[1][i] = (i == 0) ? 32'd3 : 32'd0;
    end
    for (int s = 0; s < 2; s++) begin
      c = 1'b1;
      for (int i = 0; i < WORDS; i++) begin
        // Only limb 0 sees sub=1; the latched mode must carry the rest.
        sub = (i == 0);
        drive_limb(va[s][i], vb[s][i], acc, ok);
        sub = 1'b0;
        sb.push_back(model_limb(va[s][i], vb[s][i], c, i, 1'b1, c));
        wait_out(os, ol, oc, ocyc, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok) begin
          n_err++; $display("FAIL sub_timeout set%0d limb%0d out_valid got 0 want 1", s, i);
        end else begin
          if (os !== e.sum) begin n_err++; $display("FAIL sub_sum set%0d limb%0d got %h want %h", s, i, os, e.sum); end
          n_cmp++; if (oc !== e.cout) begin n_err++; $display("FAIL sub_cout set%0d limb%0d got %b want %b", s, i, oc, e.cout); end
          n_cmp++; if (ocyc - acc !== e.lat) begin n_err++; $display("FAIL sub_latency set%0d limb%0d got %0d want %0d", s, i, ocyc - acc, e.lat); end
          @(negedge clk);
        end
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_add_table();
    test_stall();
    test_reset_mid();
`ifdef MPADD_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
